sd_cmd_scheduler: RTL and testbench
===================================

// Module: sd_cmd_scheduler
// PURPOSE
//  Round-robin arbiter and sequencer for the shared SD CMD-line engine. Collects command
//  requests from NUM_REQ clients (APB register path, card-init sequencer, data-path CMD12,
//  and others), grants one at a time, and hands it to the engine via valid/ready.
//  It then waits for completion or timeout and returns the response to the granted client.
//  It sits between the register/init logic and the CMD shifter/CRC7 engine.
// PARAMETERS
//  NUM_REQ   4   number of requesting clients (2..8)
//  TO_W      16  width of response-timeout counter
// PORTS
//  clk_i            in   1            system clock
//  reset_i          in   1            synchronous reset, active-high
//  enable_i         in   1            0: no new grants; in-flight command completes normally
//  timeout_cycles_i in   TO_W         response timeout in clk_i cycles; 0 = timeout disabled
//  req_valid_i      in   NUM_REQ      per-client request valid
//  req_idx_i        in   NUM_REQ*6    per-client command index (CMD0..CMD63)
//  req_arg_i        in   NUM_REQ*32   per-client 32-bit argument
//  req_rsp_type_i   in   NUM_REQ*2    0 none, 1 R1/R6/R7 (48b), 2 R2 (136b), 3 R1b (busy)
//  req_ready_o      out  NUM_REQ      one-hot accept pulse; request captured this cycle
//  rsp_valid_o      out  NUM_REQ      one-hot, 1-cycle response pulse to the owning client
//  rsp_data_o       out  32           card response bits [39:8] (R2: bits [127:96])
//  rsp_status_o     out  2            0 OK, 1 TIMEOUT, 2 CRC_ERR, 3 reserved
//  eng_valid_o      out  1            command frame valid toward engine
//  eng_ready_i      in   1            engine accepts frame
//  eng_idx_o        out  6            captured index
//  eng_arg_o        out  32           captured argument
//  eng_rsp_type_o   out  2            captured response type
//  eng_done_i       in   1            1-cycle pulse: response received, or busy released for R1b/none
//  eng_crc_err_i    in   1            qualified by eng_done_i: CRC7/end-bit error
//  eng_rsp_i        in   32           response payload, qualified by eng_done_i
//  eng_abort_o      out  1            1-cycle pulse: engine returns to idle, releases CMD line
//  busy_o           out  1            high in any state other than IDLE
//  grant_o          out  $clog2(NUM_REQ)  index of the current or last granted client
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr pointer = 0; timeout counter = 0; retry flag = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if enable_i and any req_valid_i, pick the first valid client at or after the rr pointer.
//          Same cycle: pulse req_ready_o[g], capture idx/arg/type, set grant_o = g.
//          rr pointer <= g+1 (mod NUM_REQ). Next state ISSUE.
//   ISSUE: eng_valid_o=1, held with stable fields until eng_ready_i. On handshake: counter := 0 -> WAIT.
//   WAIT : counter increments every cycle, saturating at all-ones.
//          On eng_done_i: latch rsp/status (CRC_ERR if eng_crc_err_i, else OK) -> RESP.
//          Else if timeout_cycles_i!=0 and counter==timeout_cycles_i-1: pulse eng_abort_o,
//          status TIMEOUT, rsp_data 0 -> RESP.
//          eng_done_i and timeout in the same cycle: done wins (status from engine).
//   RESP : rsp_valid_o[grant] = 1 for exactly one cycle; rsp_data_o/rsp_status_o hold until next RESP.
//          Next state IDLE. Earliest re-grant is the following cycle.
//  Latency: request accept to eng_valid_o = 1 cycle; eng_done_i to rsp_valid_o = 1 cycle.
//  Requests are not required to hold valid after req_ready_o; a dropped valid before grant is simply not served.
//  Clients must not withdraw mid-handshake; req_* are sampled only in the grant cycle.
//  enable_i deassert in ISSUE/WAIT: no effect on the current command.
//  reset_i mid-operation: immediate IDLE, no rsp pulse, eng_abort_o stays 0 (engine shares reset).
//  Timeout counter width TO_W: timeout_cycles_i = all-ones is legal; counter compares before saturation.
// CONFIGURATION
//  `SD_CMD_RETRY_EN defined: on CRC_ERR in WAIT with retry flag clear, set retry flag.
//   Re-enter ISSUE with the same captured fields (no RESP, no arbitration).
//   A second CRC_ERR or a TIMEOUT reports normally. Retry flag clears on entry to IDLE.
//   A timeout never retries.
//  Not defined: CRC_ERR is reported immediately; the retry flag logic is absent.
// STRUCTURE
//  sd_pkg: typedef enum sd_rsp_type_e {RSP_NONE,RSP_48,RSP_136,RSP_48B}.
//  sd_pkg: typedef enum sd_cmd_status_e {ST_OK,ST_TIMEOUT,ST_CRC_ERR}.
//  sd_pkg: typedef struct sd_cmd_req_t {idx,arg,rsp_type}; FSM state enum local.
//  One sub-module: sd_rr_arbiter (NUM_REQ-wide round-robin pick from valid mask + pointer, combinational).
// TESTING
//  1 Single req on client 0: CMD8 arg 0x000001AA, eng_ready after 2 cycles, done with rsp 0x000001AA.
//    -> rsp_valid_o=4'b0001, status OK, data 0x000001AA.
//  2 All 4 valid continuously, engine done 3 cycles after accept.
//    -> grant order 0,1,2,3,0; each client gets exactly one rsp pulse per round.
//  3 timeout_cycles_i=10, engine never done.
//    -> eng_abort_o pulses exactly 10 cycles after handshake; status TIMEOUT; data 0.
//  4 eng_done_i with eng_crc_err_i=1, twice.
//    -> without macro: CRC_ERR after first; with SD_CMD_RETRY_EN: second eng_valid_o with same fields, then CRC_ERR.
//  5 eng_done_i and timeout coincide -> status OK, no eng_abort_o.
//    enable_i=0 with pending reqs -> no req_ready_o.
//  6 reset_i asserted in WAIT -> next cycle busy_o=0, no rsp_valid_o, rr pointer 0.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// sd_pkg: shared types for the SD CMD-line scheduler (response types, status codes, request record).
// Revision: 1.0
package sd_pkg;

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_48   = 2'd1,
      RSP_136  = 2'd2,
      RSP_48B  = 2'd3
   } sd_rsp_type_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_CRC_ERR = 2'd2
   } sd_cmd_status_e;

   typedef struct packed {
      logic [5:0]   idx;
      logic [31:0]  arg;
      sd_rsp_type_e rsp_type;
   } sd_cmd_req_t;

endpackage
`default_nettype wire

// File: rtl/sd_rr_arbiter.sv
`default_nettype none
// sd_rr_arbiter: combinational round-robin pick of the first valid client at or after ptr.
// Revision: 1.0
module sd_rr_arbiter
   import sd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [GW-1:0]      ptr,
   output logic               any,
   output logic [GW-1:0]      grant,
   output logic [NUM_REQ-1:0] onehot
);

   // Scan from farthest to nearest so the last hit is the closest client to ptr.
   always_comb begin
      any    = 1'b0;
      grant  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid[(int'(ptr) + i) % NUM_REQ]) begin
            any   = 1'b1;
            grant = GW'((int'(ptr) + i) % NUM_REQ);
         end
      end
      onehot = any ? (NUM_REQ'(1) << grant) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_scheduler.sv
`default_nettype none
// sd_cmd_scheduler: round-robin arbiter/sequencer in front of the shared SD CMD engine.
// Optional macro SD_CMD_RETRY_EN: one automatic re-issue after a CRC error. Revision: 1.0
module sd_cmd_scheduler
   import sd_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TO_W    = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       enable_i,
   input  logic [TO_W-1:0]            timeout_cycles_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*6-1:0]       req_idx_i,
   input  logic [NUM_REQ*32-1:0]      req_arg_i,
   input  logic [NUM_REQ*2-1:0]       req_rsp_type_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic [NUM_REQ-1:0]         rsp_valid_o,
   output logic [31:0]                rsp_data_o,
   output logic [1:0]                 rsp_status_o,
   output logic                       eng_valid_o,
   input  logic                       eng_ready_i,
   output logic [5:0]                 eng_idx_o,
   output logic [31:0]                eng_arg_o,
   output logic [1:0]                 eng_rsp_type_o,
   input  logic                       eng_done_i,
   input  logic                       eng_crc_err_i,
   input  logic [31:0]                eng_rsp_i,
   output logic                       eng_abort_o,
   output logic                       busy_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_o
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e         state, state_next;
   logic [GW-1:0]  ptr, pick;
   logic [NUM_REQ-1:0] pick_onehot;
   logic           pick_any;
   sd_cmd_req_t    cur;
   logic [TO_W-1:0] cnt;
   logic [31:0]    rsp_data;
   sd_cmd_status_e rsp_status;
   logic           accept, handshake, timeout_hit, abort, finish;
`ifdef SD_CMD_RETRY_EN
   logic           retry, retry_take;
`endif

   sd_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
      .valid  (req_valid_i),
      .ptr    (ptr),
      .any    (pick_any),
      .grant  (pick),
      .onehot (pick_onehot)
   );

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      handshake  = 1'b0;
      abort      = 1'b0;
      finish     = 1'b0;
`ifdef SD_CMD_RETRY_EN
      retry_take = 1'b0;
`endif
      timeout_hit = (timeout_cycles_i != '0) && (cnt == timeout_cycles_i - TO_W'(1));
      case (state)
         IDLE: begin
            if (enable_i && pick_any) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (eng_ready_i) begin
               handshake  = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (eng_done_i) begin
`ifdef SD_CMD_RETRY_EN
               if (eng_crc_err_i && !retry) begin
                  retry_take = 1'b1;
                  state_next = ISSUE;
               end else begin
                  finish     = 1'b1;
                  state_next = RESP;
               end
`else
               finish     = 1'b1;
               state_next = RESP;
`endif
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         ptr        <= '0;
         grant_o    <= '0;
         cur        <= '0;
         cnt        <= '0;
         rsp_data   <= '0;
         rsp_status <= ST_OK;
`ifdef SD_CMD_RETRY_EN
         retry      <= 1'b0;
`endif
      end else begin
         state <= state_next;
         if (accept) begin
            cur.idx      <= req_idx_i[int'(pick)*6 +: 6];
            cur.arg      <= req_arg_i[int'(pick)*32 +: 32];
            cur.rsp_type <= sd_rsp_type_e'(req_rsp_type_i[int'(pick)*2 +: 2]);
            grant_o      <= pick;
            ptr          <= (pick == GW'(NUM_REQ - 1)) ? '0 : pick + GW'(1);
         end
         if (handshake) begin
            cnt <= '0;
         end else if (state == WAIT && !(&cnt)) begin
            cnt <= cnt + TO_W'(1);
         end
         if (finish) begin
            rsp_data   <= eng_rsp_i;
            rsp_status <= eng_crc_err_i ? ST_CRC_ERR : ST_OK;
         end else if (abort) begin
            rsp_data   <= '0;
            rsp_status <= ST_TIMEOUT;
         end
`ifdef SD_CMD_RETRY_EN
         if (retry_take) begin
            retry <= 1'b1;
         end else if (state == RESP) begin
            retry <= 1'b0;
         end
`endif
      end
   end

   assign req_ready_o    = (accept && !reset_i) ? pick_onehot : '0;
   assign rsp_valid_o    = (state == RESP && !reset_i) ? (NUM_REQ'(1) << grant_o) : '0;
   assign eng_valid_o    = (state == ISSUE) && !reset_i;
   assign eng_abort_o    = abort && !reset_i;
   assign busy_o         = (state != IDLE);
   assign eng_idx_o      = cur.idx;
   assign eng_arg_o      = cur.arg;
   assign eng_rsp_type_o = cur.rsp_type;
   assign rsp_data_o     = rsp_data;
   assign rsp_status_o   = rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_scheduler.sv
`default_nettype none
// tb_sd_cmd_scheduler: directed self-checking bench for sd_cmd_scheduler (engine driven by hand).
// Revision: 1.0
module tb_sd_cmd_scheduler;

   localparam int N    = 4;
   localparam int TO_W = 16;

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic            enable_i;
   logic [TO_W-1:0] timeout_cycles_i;
   logic [N-1:0]    req_valid_i;
   logic [N*6-1:0]  req_idx_i;
   logic [N*32-1:0] req_arg_i;
   logic [N*2-1:0]  req_rsp_type_i;
   logic [N-1:0]    req_ready_o;
   logic [N-1:0]    rsp_valid_o;
   logic [31:0]     rsp_data_o;
   logic [1:0]      rsp_status_o;
   logic            eng_valid_o;
   logic            eng_ready_i;
   logic [5:0]      eng_idx_o;
   logic [31:0]     eng_arg_o;
   logic [1:0]      eng_rsp_type_o;
   logic            eng_done_i;
   logic            eng_crc_err_i;
   logic [31:0]     eng_rsp_i;
   logic            eng_abort_o;
   logic            busy_o;
   logic [1:0]      grant_o;

   int checks = 0;
   int errors = 0;
   int rsp_cnt [N];

   always #5 clk_i = ~clk_i;

   sd_cmd_scheduler #(.NUM_REQ(N), .TO_W(TO_W)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .enable_i         (enable_i),
      .timeout_cycles_i (timeout_cycles_i),
      .req_valid_i      (req_valid_i),
      .req_idx_i        (req_idx_i),
      .req_arg_i        (req_arg_i),
      .req_rsp_type_i   (req_rsp_type_i),
      .req_ready_o      (req_ready_o),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_data_o       (rsp_data_o),
      .rsp_status_o     (rsp_status_o),
      .eng_valid_o      (eng_valid_o),
      .eng_ready_i      (eng_ready_i),
      .eng_idx_o        (eng_idx_o),
      .eng_arg_o        (eng_arg_o),
      .eng_rsp_type_o   (eng_rsp_type_o),
      .eng_done_i       (eng_done_i),
      .eng_crc_err_i    (eng_crc_err_i),
      .eng_rsp_i        (eng_rsp_i),
      .eng_abort_o      (eng_abort_o),
      .busy_o           (busy_o),
      .grant_o          (grant_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int c, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [1:0] t);
      req_idx_i[c*6 +: 6]       = idx;
      req_arg_i[c*32 +: 32]     = arg;
      req_rsp_type_i[c*2 +: 2]  = t;
      req_valid_i[c]            = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_i = 1'b1; enable_i = 1'b0; timeout_cycles_i = '0;
      req_valid_i = '0; req_idx_i = '0; req_arg_i = '0; req_rsp_type_i = '0;
      eng_ready_i = 1'b0; eng_done_i = 1'b0; eng_crc_err_i = 1'b0; eng_rsp_i = '0;
      foreach (rsp_cnt[c]) rsp_cnt[c] = 0;
      repeat (3) tick();
      reset_i = 1'b0;
      tick();

      // Reset state
      chk("rst_busy",      64'(busy_o), 64'd0);
      chk("rst_eng_valid", 64'(eng_valid_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_grant",     64'(grant_o), 64'd0);
      chk("rst_status",    64'(rsp_status_o), 64'd0);
      chk("rst_data",      64'(rsp_data_o), 64'd0);
      chk("rst_abort",     64'(eng_abort_o), 64'd0);

      // Test 1: single CMD8 on client 0, engine ready after 2 cycles
      enable_i = 1'b1;
      set_req(0, 6'd8, 32'h0000_01AA, 2'd1);
      #1 chk("t1_ready", 64'(req_ready_o), 64'h1);
      tick(); req_valid_i = '0;
      #1;
      chk("t1_eng_valid", 64'(eng_valid_o), 64'd1);
      chk("t1_eng_idx",   64'(eng_idx_o), 64'd8);
      chk("t1_eng_arg",   64'(eng_arg_o), 64'h1AA);
      chk("t1_eng_type",  64'(eng_rsp_type_o), 64'd1);
      chk("t1_grant",     64'(grant_o), 64'd0);
      chk("t1_busy",      64'(busy_o), 64'd1);
      tick();
      chk("t1_hold", 64'(eng_valid_o), 64'd1);
      tick(); eng_ready_i = 1'b1;
      tick(); eng_ready_i = 1'b0;
      #1 chk("t1_wait_no_valid", 64'(eng_valid_o), 64'd0);
      tick(); eng_done_i = 1'b1; eng_rsp_i = 32'h0000_01AA;
      tick(); eng_done_i = 1'b0;
      #1;
      chk("t1_rsp_valid",  64'(rsp_valid_o), 64'h1);
      chk("t1_rsp_status", 64'(rsp_status_o), 64'd0);
      chk("t1_rsp_data",   64'(rsp_data_o), 64'h1AA);
      tick();
      chk("t1_rsp_once", 64'(rsp_valid_o), 64'd0);
      chk("t1_idle",     64'(busy_o), 64'd0);

      // Test 2: four clients continuously valid, done 3 cycles after accept
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      for (int c = 0; c < N; c++) set_req(c, 6'(c + 1), 32'h1000 + 32'(c), 2'd1);
      for (int r = 0; r < 5; r++) begin
         int g;
         g = r % N;
         #1 chk($sformatf("t2_ready_r%0d", r), 64'(req_ready_o), 64'(4'b0001 << g));
         tick(); eng_ready_i = 1'b1;
         #1;
         chk($sformatf("t2_grant_r%0d", r), 64'(grant_o), 64'(g));
         chk($sformatf("t2_idx_r%0d", r),   64'(eng_idx_o), 64'(g + 1));
         tick(); eng_ready_i = 1'b0;
         tick(); eng_done_i = 1'b1; eng_rsp_i = 32'h100 + 32'(g);
         tick(); eng_done_i = 1'b0;
         #1;
         chk($sformatf("t2_rsp_r%0d", r),  64'(rsp_valid_o), 64'(4'b0001 << g));
         chk($sformatf("t2_data_r%0d", r), 64'(rsp_data_o), 64'h100 + 64'(g));
         for (int c = 0; c < N; c++) if (rsp_valid_o[c]) rsp_cnt[c]++;
         tick();
      end
      req_valid_i = '0;
      chk("t2_cnt0", 64'(rsp_cnt[0]), 64'd2);
      chk("t2_cnt1", 64'(rsp_cnt[1]), 64'd1);
      chk("t2_cnt2", 64'(rsp_cnt[2]), 64'd1);
      chk("t2_cnt3", 64'(rsp_cnt[3]), 64'd1);

      // Test 3: timeout of 10 cycles, engine never completes
      timeout_cycles_i = 16'd10;
      set_req(1, 6'd2, 32'h0, 2'd1);
      #1 chk("t3_ready", 64'(req_ready_o), 64'h2);
      tick(); req_valid_i = '0; eng_ready_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(); eng_ready_i = 1'b0;
         #1 chk($sformatf("t3_abort_k%0d", k), 64'(eng_abort_o), 64'(k == 10));
      end
      tick();
      chk("t3_rsp_valid",  64'(rsp_valid_o), 64'h2);
      chk("t3_rsp_status", 64'(rsp_status_o), 64'd1);
      chk("t3_rsp_data",   64'(rsp_data_o), 64'd0);
      chk("t3_no_abort",   64'(eng_abort_o), 64'd0);
      timeout_cycles_i = '0;
      tick();

      // Test 4: CRC error on completion
      set_req(2, 6'd17, 32'hDEAD_BEEF, 2'd1);
      #1 chk("t4_ready", 64'(req_ready_o), 64'h4);
      tick(); req_valid_i = '0; eng_ready_i = 1'b1;
      tick(); eng_ready_i = 1'b0; eng_done_i = 1'b1; eng_crc_err_i = 1'b1; eng_rsp_i = 32'h1234;
      tick(); eng_done_i = 1'b0; eng_crc_err_i = 1'b0;
      #1;
`ifdef SD_CMD_RETRY_EN
      chk("t4_retry_valid", 64'(eng_valid_o), 64'd1);
      chk("t4_retry_idx",   64'(eng_idx_o), 64'd17);
      chk("t4_retry_arg",   64'(eng_arg_o), 64'hDEAD_BEEF);
      chk("t4_retry_norsp", 64'(rsp_valid_o), 64'd0);
      eng_ready_i = 1'b1;
      tick(); eng_ready_i = 1'b0; eng_done_i = 1'b1; eng_crc_err_i = 1'b1; eng_rsp_i = 32'h5678;
      tick(); eng_done_i = 1'b0; eng_crc_err_i = 1'b0;
      #1;
      chk("t4_rsp_valid",  64'(rsp_valid_o), 64'h4);
      chk("t4_rsp_status", 64'(rsp_status_o), 64'd2);
      chk("t4_rsp_data",   64'(rsp_data_o), 64'h5678);
`else
      chk("t4_rsp_valid",  64'(rsp_valid_o), 64'h4);
      chk("t4_rsp_status", 64'(rsp_status_o), 64'd2);
      chk("t4_rsp_data",   64'(rsp_data_o), 64'h1234);
      chk("t4_no_reissue", 64'(eng_valid_o), 64'd0);
`endif
      tick();

      // Test 5: done coincides with timeout; then enable_i low blocks grants
      timeout_cycles_i = 16'd4;
      set_req(3, 6'd13, 32'h0, 2'd0);
      #1 chk("t5_ready", 64'(req_ready_o), 64'h8);
      tick(); req_valid_i = '0; eng_ready_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick(); eng_ready_i = 1'b0;
         #1 chk($sformatf("t5_abort_k%0d", k), 64'(eng_abort_o), 64'd0);
      end
      tick(); eng_done_i = 1'b1; eng_rsp_i = 32'hCAFE;
      #1 chk("t5_coincide_no_abort", 64'(eng_abort_o), 64'd0);
      tick(); eng_done_i = 1'b0;
      #1;
      chk("t5_rsp_valid",  64'(rsp_valid_o), 64'h8);
      chk("t5_rsp_status", 64'(rsp_status_o), 64'd0);
      chk("t5_rsp_data",   64'(rsp_data_o), 64'hCAFE);
      timeout_cycles_i = '0;
      tick();
      enable_i = 1'b0;
      req_valid_i = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t5_disabled_ready_%0d", k), 64'(req_ready_o), 64'd0);
         chk($sformatf("t5_disabled_busy_%0d", k),  64'(busy_o), 64'd0);
         tick();
      end
      enable_i = 1'b1;
      #1 chk("t5_enable_ready", 64'(req_ready_o), 64'h1);

      // Test 6: reset while waiting for the engine
      tick(); req_valid_i = '0; eng_ready_i = 1'b1;
      tick(); eng_ready_i = 1'b0;
      tick();
      #1 chk("t6_in_wait", 64'(busy_o), 64'd1);
      reset_i = 1'b1;
      tick(); reset_i = 1'b0;
      #1;
      chk("t6_busy",      64'(busy_o), 64'd0);
      chk("t6_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("t6_abort",     64'(eng_abort_o), 64'd0);
      chk("t6_eng_valid", 64'(eng_valid_o), 64'd0);
      req_valid_i = 4'b1111;
      #1 chk("t6_ptr_zero", 64'(req_ready_o), 64'h1);
      req_valid_i = '0;
      enable_i = 1'b0;
      tick();
      chk("t6_idle_after", 64'(busy_o), 64'd0);
      chk("t6_no_rsp",     64'(rsp_valid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
